// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Also used by other arbiters that need a source-id width.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE,
      XFER
   } state_e;

   function automatic int id_width(input int n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [3:0] onehot2bin(input logic [15:0] oh);
      logic [3:0] b;
      b = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) b = b | 4'(i);
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first request at or after ptr,
// wrapping modulo N.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]             req_i,
   input  logic [id_width(N)-1:0]   ptr_i,
   output logic [N-1:0]             gnt_o,
   output logic                     any_o
);

   localparam int IDW = id_width(N);

   logic [IDW:0]   sum;
   logic [IDW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      any_o = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_i} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
         idx = sum[IDW-1:0];
         if (!any_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            any_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin packet arbiter for the write port of an async FIFO.
// Each written word is tagged {src_id, last, data}.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N         = 4,
   parameter int DW        = 8,
   parameter int MAX_BEATS = 64
) (
   input  logic                     wclk,
   input  logic                     wrst,
   input  logic [N-1:0]             s_valid,
   input  logic [N-1:0]             s_last,
   input  logic [N*DW-1:0]          s_data,
   output logic [N-1:0]             s_ready,
   input  logic                     wfull,
   output logic                     winc,
   output logic [id_width(N)+DW:0]  wdata,
   output logic [N-1:0]             grant,
   output logic                     busy,
   output logic                     overrun
);

   localparam int IDW = id_width(N);
   localparam int CW  = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);
   localparam logic [CW-1:0] CNT_LIM = CW'(MAX_BEATS - 1);

   state_e         state_q, state_d;
   logic [N-1:0]   grant_q, grant_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           ovr_q, ovr_d;

   logic [N-1:0]   pick;
   logic           pick_any;
   logic [IDW-1:0] gidx;
   logic           sel_valid, sel_last;
   logic [DW-1:0]  sel_data;
   logic           xfer, open, fire;

   rr_pick #(.N(N)) u_pick (
      .req_i (s_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick),
      .any_o (pick_any)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) sel_data = sel_data | s_data[i*DW +: DW];
      end
   end

   assign gidx      = IDW'(onehot2bin(16'(grant_q)));
   assign sel_valid = |(s_valid & grant_q);
   assign sel_last  = |(s_last & grant_q);

   // Reset gates the handshake combinationally, whatever the state.
   assign xfer = (state_q == XFER);
   assign open = xfer & ~wfull & ~wrst;
   assign fire = open & sel_valid;

   assign s_ready = open ? grant_q : '0;
   assign winc    = fire;
   assign wdata   = {gidx, sel_last, sel_data};
   assign grant   = grant_q;
   assign busy    = xfer;
   assign overrun = ovr_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = XFER;
               grant_d = pick;
               cnt_d   = '0;
            end
         end
         XFER: begin
            if (fire) begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
               if (!sel_last && cnt_q == CNT_LIM) ovr_d = 1'b1;
               if (sel_last) begin
                  state_d = IDLE;
                  grant_d = '0;
                  ptr_d   = (gidx == IDW'(N-1)) ? '0 : gidx + IDW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (N=4, DW=8, MAX_BEATS=64).
// Per-cycle vector table plus hand sequences for the multi-cycle cases.
module tb_fifo_write_arbiter;

   logic        wclk = 1'b0;
   logic        wrst;
   logic [3:0]  s_valid, s_last, s_ready, grant;
   logic [31:0] s_data;
   logic        wfull, winc, busy, overrun;
   logic [10:0] wdata;

   int nvec = 0;
   int nerr = 0;

   fifo_write_arbiter #(.N(4), .DW(8), .MAX_BEATS(64)) dut (
      .wclk    (wclk),
      .wrst    (wrst),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_data  (s_data),
      .s_ready (s_ready),
      .wfull   (wfull),
      .winc    (winc),
      .wdata   (wdata),
      .grant   (grant),
      .busy    (busy),
      .overrun (overrun)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  l;
      logic [31:0] d;
      logic        wf;
      logic [3:0]  er;
      logic        ew;
      logic [10:0] ewd;
      logic [3:0]  eg;
      logic        eb;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [10:0] wd(input logic [1:0] id, input logic l,
                                      input logic [7:0] d);
      return {id, l, d};
   endfunction

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l,
                               input logic [31:0] d, input logic wf,
                               input logic [3:0] er, input logic ew,
                               input logic [10:0] ewd, input logic [3:0] eg,
                               input logic eb);
      vec_t r;
      r.v = v; r.l = l; r.d = d; r.wf = wf;
      r.er = er; r.ew = ew; r.ewd = ewd; r.eg = eg; r.eb = eb;
      return r;
   endfunction

   task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                        input logic [31:0] d, input logic wf);
      @(negedge wclk);
      wrst = r; s_valid = v; s_last = l; s_data = d; wfull = wf;
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] er, input logic ew,
                      input logic [10:0] ewd, input logic [3:0] eg,
                      input logic eb, input logic eo);
      nvec++;
      if (s_ready !== er || winc !== ew || (ew && wdata !== ewd) ||
          grant !== eg || busy !== eb || overrun !== eo) begin
         nerr++;
         $display("FAIL %s: got ready=%b winc=%b wdata=%h grant=%b busy=%b ovr=%b, want ready=%b winc=%b wdata=%h grant=%b busy=%b ovr=%b",
                  nm, s_ready, winc, wdata, grant, busy, overrun,
                  er, ew, ewd, eg, eb, eo);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] bb;
      logic [3:0] src_oh;
      logic [1:0] src_id;

      // test 1: src2 3-beat packet
      tbl.push_back(mk(4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, 4'b0000, 1'b0, '0, 4'b0000, 1'b0));
      tbl.push_back(mk(4'b0100, 4'b0000, 32'h00A1_0000, 1'b0, 4'b0100, 1'b1, wd(2, 0, 8'hA1), 4'b0100, 1'b1));
      tbl.push_back(mk(4'b0100, 4'b0000, 32'h00A2_0000, 1'b0, 4'b0100, 1'b1, wd(2, 0, 8'hA2), 4'b0100, 1'b1));
      tbl.push_back(mk(4'b0100, 4'b0100, 32'h00A3_0000, 1'b0, 4'b0100, 1'b1, wd(2, 1, 8'hA3), 4'b0100, 1'b1));
      tbl.push_back(mk(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, '0, 4'b0000, 1'b0));
      // test 2: all valid, single-beat packets; pointer left at 3
      for (int k = 0; k < 6; k++) begin
         src_id = 2'((3 + k) % 4);
         src_oh = 4'b0001 << src_id;
         bb     = 8'h10 + 8'(src_id);
         tbl.push_back(mk(4'b1111, 4'b1111, 32'h1312_1110, 1'b0, 4'b0000, 1'b0, '0, 4'b0000, 1'b0));
         tbl.push_back(mk(4'b1111, 4'b1111, 32'h1312_1110, 1'b0, src_oh, 1'b1, wd(src_id, 1, bb), src_oh, 1'b1));
      end
      // test 4: wfull held 5 cycles mid-packet
      tbl.push_back(mk(4'b0010, 4'b0000, 32'h0000_5100, 1'b0, 4'b0000, 1'b0, '0, 4'b0000, 1'b0));
      tbl.push_back(mk(4'b0010, 4'b0000, 32'h0000_5100, 1'b0, 4'b0010, 1'b1, wd(1, 0, 8'h51), 4'b0010, 1'b1));
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(4'b0010, 4'b0000, 32'h0000_5200, 1'b1, 4'b0000, 1'b0, '0, 4'b0010, 1'b1));
      tbl.push_back(mk(4'b0010, 4'b0010, 32'h0000_5200, 1'b0, 4'b0010, 1'b1, wd(1, 1, 8'h52), 4'b0010, 1'b1));
      tbl.push_back(mk(4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, '0, 4'b0000, 1'b0));

      wrst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; wfull = 1'b0;
      drive(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b0);
      drive(1'b1, 4'b0000, 4'b0000, 32'h0, 1'b0);
      chk("reset", 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 1'b0);

      foreach (tbl[i]) begin
         drive(1'b0, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].wf);
         chk($sformatf("vec%0d", i), tbl[i].er, tbl[i].ew, tbl[i].ewd,
             tbl[i].eg, tbl[i].eb, 1'b0);
      end

      // test 3: src0 4-beat packet holds off src1
      drive(1'b0, 4'b0011, 4'b0010, 32'h0000_D0C0, 1'b0);
      chk("t3_idle", 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         bb = 8'hC0 + 8'(k);
         drive(1'b0, 4'b0011, {2'b00, 1'b1, (k == 3)}, {16'h0, 8'hD0, bb}, 1'b0);
         chk($sformatf("t3_src0_b%0d", k), 4'b0001, 1'b1,
             wd(0, (k == 3), bb), 4'b0001, 1'b1, 1'b0);
      end
      drive(1'b0, 4'b0010, 4'b0010, 32'h0000_D000, 1'b0);
      chk("t3_bubble", 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 1'b0);
      drive(1'b0, 4'b0010, 4'b0010, 32'h0000_D000, 1'b0);
      chk("t3_src1", 4'b0010, 1'b1, wd(1, 1, 8'hD0), 4'b0010, 1'b1, 1'b0);

      // test 5: 65-beat packet on src3 trips overrun
      drive(1'b0, 4'b1000, 4'b0000, 32'h0, 1'b0);
      chk("t5_idle", 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 1'b0);
      for (int b = 1; b <= 65; b++) begin
         bb = 8'(b);
         drive(1'b0, 4'b1000, {(b == 65), 3'b000}, {bb, 24'h0}, 1'b0);
         chk($sformatf("t5_b%0d", b), 4'b1000, 1'b1, wd(3, (b == 65), bb),
             4'b1000, 1'b1, (b > 64));
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0);
         chk($sformatf("t5_sticky%0d", k), 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 1'b1);
      end

      // test 6: reset after 2 of 4 beats
      drive(1'b0, 4'b1000, 4'b0000, 32'h0, 1'b0);
      chk("t6_idle", 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 1'b1);
      drive(1'b0, 4'b1000, 4'b0000, 32'hE100_0000, 1'b0);
      chk("t6_b1", 4'b1000, 1'b1, wd(3, 0, 8'hE1), 4'b1000, 1'b1, 1'b1);
      drive(1'b0, 4'b1000, 4'b0000, 32'hE200_0000, 1'b0);
      chk("t6_b2", 4'b1000, 1'b1, wd(3, 0, 8'hE2), 4'b1000, 1'b1, 1'b1);
      drive(1'b1, 4'b1000, 4'b0000, 32'hE300_0000, 1'b0);
      nvec++;
      if (s_ready !== 4'b0000 || winc !== 1'b0) begin
         nerr++;
         $display("FAIL t6_rst_cycle: got ready=%b winc=%b, want ready=0000 winc=0",
                  s_ready, winc);
      end
      drive(1'b0, 4'b1010, 4'b1010, 32'hF300_F100, 1'b0);
      chk("t6_after_rst", 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 1'b0);
      drive(1'b0, 4'b1010, 4'b1010, 32'hF300_F100, 1'b0);
      chk("t6_from_src0", 4'b0010, 1'b1, wd(1, 1, 8'hF1), 4'b0010, 1'b1, 1'b0);

      // exactly MAX_BEATS beats with last: no overrun
      drive(1'b0, 4'b0001, 4'b0000, 32'h0, 1'b0);
      chk("t7_idle", 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 1'b0);
      for (int b = 1; b <= 64; b++) begin
         bb = 8'(b);
         drive(1'b0, 4'b0001, {3'b000, (b == 64)}, {24'h0, bb}, 1'b0);
         if (b == 1 || b >= 63)
            chk($sformatf("t7_b%0d", b), 4'b0001, 1'b1, wd(0, (b == 64), bb),
                4'b0001, 1'b1, 1'b0);
      end
      drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0);
      chk("t7_no_ovr", 4'b0000, 1'b0, '0, 4'b0000, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
